// File: rtl/note_scroller.sv
// note_scroller: scrolls a LANES x DEPTH note field one row toward the hit row
// on each divider tick, loads a fresh pattern row at the top, and judges key
// presses against the bottom (hit) row. Tracks score, streak and misses; the
// game ends once the miss count reaches MAX_MISS.
//
// Handshake: pattern_req is a combinational strobe, high exactly in the cycle
// the block consumes pattern_in (a RUN-state tick not overridden by start).
// The source must hold pattern_in valid for any cycle tick may be high; there
// is no back-pressure.
module note_scroller #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int MAX_MISS = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   tick,
  input  logic                   start,
  input  logic [LANES-1:0]       pattern_in,
  output logic                   pattern_req,
  input  logic [LANES-1:0]       key_in,
  output logic [LANES*DEPTH-1:0] field,
  output logic                   hit,
  output logic                   wrong,
  output logic                   miss,
  output logic [15:0]            score,
  output logic [7:0]             streak,
  output logic [3:0]             misses,
  output logic [1:0]             state
);

  localparam int FW = LANES * DEPTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    field_q, field_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       streak_q, streak_d;
  logic [3:0]       misses_q, misses_d;
  logic             hit_q, hit_d;
  logic             wrong_q, wrong_d;
  logic             miss_q, miss_d;
  logic [LANES-1:0] key_prev_q;

  logic [LANES-1:0] press, hitrow, hits, bad, missed;
  logic [FW-1:0]    field_clr;
  logic [7:0]       hits_cnt, missed_cnt;
  logic [16:0]      score_sum;
  logic [8:0]       streak_sum;
  logic [7:0]       misses_sum;

  function automatic logic [7:0] popcnt(input logic [LANES-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < LANES; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  // Rising-edge press detection and judging against the current hit row.
  assign press      = key_in & ~key_prev_q;
  assign hitrow     = field_q[(DEPTH-1)*LANES +: LANES];
  assign hits       = press & hitrow;
  assign bad        = press & ~hitrow;
  assign missed     = hitrow & ~hits;
  assign field_clr  = field_q & ~{hits, {(FW-LANES){1'b0}}};
  assign hits_cnt   = popcnt(hits);
  assign missed_cnt = popcnt(missed);
  assign score_sum  = {1'b0, score_q} + {9'd0, hits_cnt};
  assign streak_sum = {1'b0, streak_q} + {1'b0, hits_cnt};
  assign misses_sum = {4'd0, misses_q} + missed_cnt;

  assign pattern_req = resetn && (state_q == S_RUN) && tick && !start;

  // Next-state logic: start overrides everything, RUN judges and scrolls.
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    score_d  = score_q;
    streak_d = streak_q;
    misses_d = misses_q;
    hit_d    = 1'b0;
    wrong_d  = 1'b0;
    miss_d   = 1'b0;
    if (start) begin
      state_d  = S_RUN;
      field_d  = '0;
      score_d  = '0;
      streak_d = '0;
      misses_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          field_d  = field_clr;
          hit_d    = |hits;
          wrong_d  = |bad;
          score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (|bad) streak_d = 8'd0;
          else      streak_d = streak_sum[8] ? 8'hFF : streak_sum[7:0];
          if (tick) begin
            field_d = {field_clr[FW-LANES-1:0], pattern_in};
            if (|missed) begin
              miss_d   = 1'b1;
              misses_d = (misses_sum > 8'd15) ? 4'd15 : misses_sum[3:0];
              streak_d = 8'd0;
            end
          end
          if (misses_q >= 4'(MAX_MISS)) state_d = S_DONE;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      field_q    <= '0;
      score_q    <= '0;
      streak_q   <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      wrong_q    <= 1'b0;
      miss_q     <= 1'b0;
      key_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
      misses_q   <= misses_d;
      hit_q      <= hit_d;
      wrong_q    <= wrong_d;
      miss_q     <= miss_d;
      key_prev_q <= key_in;
    end
  end

  assign field  = field_q;
  assign score  = score_q;
  assign streak = streak_q;
  assign misses = misses_q;
  assign hit    = hit_q;
  assign wrong  = wrong_q;
  assign miss   = miss_q;
  assign state  = state_q;

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller: inputs change 1ns after the rising edge,
// outputs are checked there too; pattern_req strobes are counted on the
// falling edge.
module tb_note_scroller;

  logic        clk = 1'b0;
  logic        resetn, tick, start;
  logic [3:0]  pattern_in, key_in;
  logic        pattern_req, hit, wrong, miss;
  logic [31:0] field;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [3:0]  misses;
  logic [1:0]  state;

  int tests_run = 0;
  int tests_failed = 0;
  int preq_cnt = 0;
  int preq_snap;

  note_scroller #(.LANES(4), .DEPTH(8), .MAX_MISS(8)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start),
    .pattern_in(pattern_in), .pattern_req(pattern_req), .key_in(key_in),
    .field(field), .hit(hit), .wrong(wrong), .miss(miss),
    .score(score), .streak(streak), .misses(misses), .state(state)
  );

  // Clock and pattern_req strobe counter.
  always #5 clk = ~clk;
  always @(negedge clk) if (pattern_req === 1'b1) preq_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input logic [3:0] pat);
    pattern_in = pat;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    pattern_in = 4'd0;
    cyc();
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; start = 1'b0;
    pattern_in = 4'd0; key_in = 4'd0;
    cyc(); cyc();
    resetn = 1'b1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_field", field, 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_streak", 32'(streak), 32'h0);
    chk("rst_misses", 32'(misses), 32'h0);
    chk("rst_pulses", {28'd0, hit, wrong, miss, pattern_req}, 32'h0);

    // Ticks in IDLE are ignored.
    do_tick(4'b1111);
    chk("idle_field", field, 32'h0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_state", 32'(state), 32'h1);
    preq_cnt = 0;

    // Test 1: a lane-0 note walks down to the hit row in 8 ticks.
    do_tick(4'b0001);
    chk("t1_row0", field, 32'h0000_0001);
    for (int k = 2; k <= 8; k++) do_tick(4'b0000);
    chk("t1_row7", field, 32'h1000_0000);
    chk("t1_preq", 32'(preq_cnt), 32'd8);

    // Test 2: press key 0 one cycle after tick 8.
    key_in = 4'b0001; cyc();
    chk("t2_hit", 32'(hit), 32'h1);
    chk("t2_score", 32'(score), 32'd1);
    chk("t2_streak", 32'(streak), 32'd1);
    chk("t2_field", field, 32'h0);
    key_in = 4'b0000;
    do_tick(4'b0000);
    chk("t2_miss", 32'(miss), 32'h0);
    chk("t2_misses", 32'(misses), 32'h0);

    // Test 3: lane-2 note hit in the same cycle as the next tick.
    do_tick(4'b0100);
    for (int k = 0; k < 7; k++) do_tick(4'b0000);
    chk("t3_row7", field, 32'h4000_0000);
    key_in = 4'b0100; tick = 1'b1; cyc(); tick = 1'b0;
    chk("t3_hit", 32'(hit), 32'h1);
    chk("t3_miss", 32'(miss), 32'h0);
    chk("t3_score", 32'(score), 32'd2);
    chk("t3_streak", 32'(streak), 32'd2);
    chk("t3_field", field, 32'h0);
    key_in = 4'b0000; cyc();
    chk("t3_hit_pulse", 32'(hit), 32'h0);

    // Test 4: correct key plus a wrong key in the same cycle.
    do_tick(4'b0001);
    for (int k = 0; k < 7; k++) do_tick(4'b0000);
    key_in = 4'b0011; cyc();
    chk("t4_hitwrong", {30'd0, hit, wrong}, 32'h3);
    chk("t4_score", 32'(score), 32'd3);
    chk("t4_streak", 32'(streak), 32'd0);
    chk("t4_field", field, 32'h0);
    key_in = 4'b0000; cyc();

    // Test 5: full rows with no presses run the game to DONE.
    for (int k = 0; k < 8; k++) do_tick(4'b1111);
    chk("t5_full", field, 32'hFFFF_FFFF);
    chk("t5_misses0", 32'(misses), 32'd0);
    pattern_in = 4'b1111; tick = 1'b1; cyc(); tick = 1'b0;
    chk("t5_miss_pulse", 32'(miss), 32'h1);
    chk("t5_misses4", 32'(misses), 32'd4);
    cyc();
    do_tick(4'b1111);
    chk("t5_misses8", 32'(misses), 32'd8);
    cyc();
    chk("t5_done", 32'(state), 32'h2);
    preq_snap = preq_cnt;
    do_tick(4'b0000);
    do_tick(4'b0000);
    chk("t5_done_field", field, 32'hFFFF_FFFF);
    chk("t5_done_misses", 32'(misses), 32'd8);
    chk("t5_done_score", 32'(score), 32'd3);
    chk("t5_done_preq", 32'(preq_cnt), 32'(preq_snap));
    chk("t5_done_pulses", {29'd0, hit, wrong, miss}, 32'h0);

    // Test 6: keys held through reset do not count; only a re-press does.
    resetn = 1'b0; key_in = 4'b1111; tick = 1'b1; cyc(); tick = 1'b0; cyc();
    resetn = 1'b1;
    chk("t6_rst_state", 32'(state), 32'h0);
    chk("t6_rst_field", field, 32'h0);
    chk("t6_rst_score", 32'(score), 32'h0);
    start = 1'b1; cyc(); start = 1'b0;
    do_tick(4'b1000);
    for (int k = 0; k < 7; k++) do_tick(4'b0000);
    chk("t6_row7", field, 32'h8000_0000);
    chk("t6_no_press", {30'd0, hit, wrong}, 32'h0);
    chk("t6_score0", 32'(score), 32'd0);
    key_in = 4'b0111; cyc();
    chk("t6_release", {30'd0, hit, wrong}, 32'h0);
    key_in = 4'b1111; cyc();
    chk("t6_repress", {30'd0, hit, wrong}, 32'h2);
    chk("t6_score1", 32'(score), 32'd1);
    chk("t6_field", field, 32'h0);

    // Start coincident with a tick: tick dropped, field cleared.
    do_tick(4'b0010);
    chk("t6_loaded", field, 32'h0000_0002);
    preq_snap = preq_cnt;
    start = 1'b1; tick = 1'b1; pattern_in = 4'b0100;
    cyc();
    start = 1'b0; tick = 1'b0; pattern_in = 4'b0000;
    chk("t6_start_preq", 32'(preq_cnt), 32'(preq_snap));
    chk("t6_start_field", field, 32'h0);
    chk("t6_start_state", 32'(state), 32'h1);
    chk("t6_start_score", 32'(score), 32'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
